// File: rtl/cp_in_blk_asm_pkg.sv
// Shared types and constants for the AES input block assembler.
package cp_in_blk_asm_pkg;

  typedef enum logic [1:0] {
    ASM_IDLE = 2'd0,
    ASM_FILL = 2'd1,
    ASM_HOLD = 2'd2
  } asm_state_e;

  localparam logic [3:0] WD0    = 4'b0001;
  localparam logic [3:0] WD1    = 4'b0010;
  localparam logic [3:0] WD2    = 4'b0100;
  localparam logic [3:0] WD3    = 4'b1000;
  localparam logic [3:0] WD_ALL = 4'b1111;

  localparam int BLK_W  = 128;
  localparam int WORD_W = 32;

  function automatic logic is_onehot4(input logic [3:0] sel);
    return (sel == WD0) || (sel == WD1) || (sel == WD2) || (sel == WD3);
  endfunction

  // Expands a word select into a 128-bit lane mask.
  function automatic logic [BLK_W-1:0] word_mask(input logic [3:0] sel);
    logic [BLK_W-1:0] m;
    for (int n = 0; n < 4; n++) m[n*WORD_W +: WORD_W] = {WORD_W{sel[n]}};
    return m;
  endfunction

endpackage

// File: rtl/cp_blk_fifo.sv
// DEPTH x W synchronous FIFO with occupancy count; head reads zero while empty.
module cp_blk_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 135
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop_req,
  output logic                   head_vld,
  output logic [W-1:0]           head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign head_vld = ~empty;
  assign do_pop   = pop_req & ~empty & ~clr;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push  = push & (~full | do_pop) & ~clr;

  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; stale entries are unreachable
  // because the head is masked to zero whenever the count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cp_in_blk_asm.sv
// Merges four one-hot 32-bit word writes per block address into 128-bit AES
// input blocks and queues them towards the core over valid/ready.
module cp_in_blk_asm
  import cp_in_blk_asm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 7,
  parameter int DW    = BLK_W
) (
  input  logic                   iClk,
  input  logic                   iRsn,
  input  logic                   iClr,
  input  logic                   iWrEn_CpInBuf,
  input  logic [3:0]             iWdSel_CpInBuf,
  input  logic [AW-1:0]          iWrAddr_CpInBuf,
  input  logic [DW-1:0]          iWrDt_CpInBuf,
  output logic                   oBlkVld,
  input  logic                   iBlkRdy,
  output logic [AW-1:0]          oBlkAddr,
  output logic [DW-1:0]          oBlkDt,
  output logic [$clog2(DEPTH):0] oFillCnt,
  output logic                   oFull,
  output logic                   oEmpty,
  output logic                   oAsmErr,
  output logic                   oWrDrop
);

  asm_state_e    state_q, state_d;
  logic [3:0]    mask_q, mask_d, mask_merged;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d, sel_mask, data_merged, data_fresh, push_data;
  logic          asm_err_q, asm_err_d, wr_drop_q, wr_drop_d;
  logic          wr_ok, wr_bad, same_addr, blk_done, pop, push_ok, push;
  logic          blk_vld, fifo_full;

  assign wr_ok       = iWrEn_CpInBuf & is_onehot4(iWdSel_CpInBuf);
  assign wr_bad      = iWrEn_CpInBuf & ~is_onehot4(iWdSel_CpInBuf);
  assign same_addr   = (iWrAddr_CpInBuf == addr_q);
  assign sel_mask    = word_mask(iWdSel_CpInBuf);
  assign mask_merged = mask_q | iWdSel_CpInBuf;
  assign data_merged = (data_q & ~sel_mask) | (iWrDt_CpInBuf & sel_mask);
  assign data_fresh  = iWrDt_CpInBuf & sel_mask;
  assign blk_done    = wr_ok & same_addr & (mask_merged == WD_ALL);
  assign pop         = blk_vld & iBlkRdy;
  assign push_ok     = ~fifo_full | pop;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) state_q <= ASM_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: each comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ASM_IDLE: if (wr_ok) state_d = ASM_FILL;
      ASM_FILL: if (blk_done) state_d = push_ok ? ASM_IDLE : ASM_HOLD;
      ASM_HOLD: if (push_ok) state_d = ASM_IDLE;
      default:  state_d = ASM_IDLE;
    endcase
    if (iClr) state_d = ASM_IDLE;
  end

  always_comb begin
    mask_d    = mask_q;
    addr_d    = addr_q;
    data_d    = data_q;
    push      = 1'b0;
    push_data = data_q;
    asm_err_d = 1'b0;
    wr_drop_d = wr_bad;
    case (state_q)
      ASM_IDLE: begin
        if (wr_ok) begin
          mask_d = iWdSel_CpInBuf;
          addr_d = iWrAddr_CpInBuf;
          data_d = data_fresh;
        end
      end
      ASM_FILL: begin
        if (wr_ok && same_addr) begin
          mask_d    = mask_merged;
          data_d    = data_merged;
          push_data = data_merged;
          if (blk_done && push_ok) begin
            push   = 1'b1;
            mask_d = '0;
            data_d = '0;
          end
        end else if (wr_ok) begin
          // A new address abandons the partial block and restarts from this word.
          asm_err_d = 1'b1;
          mask_d    = iWdSel_CpInBuf;
          addr_d    = iWrAddr_CpInBuf;
          data_d    = data_fresh;
        end
      end
      ASM_HOLD: begin
        wr_drop_d = iWrEn_CpInBuf;
        if (push_ok) begin
          push   = 1'b1;
          mask_d = '0;
          data_d = '0;
        end
      end
      default: ;
    endcase
    if (iClr) begin
      mask_d    = '0;
      addr_d    = '0;
      data_d    = '0;
      push      = 1'b0;
      asm_err_d = 1'b0;
      wr_drop_d = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      mask_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      asm_err_q <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      asm_err_q <= asm_err_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  cp_blk_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk       (iClk),
    .rst_n     (iRsn),
    .clr       (iClr),
    .push      (push),
    .push_data ({addr_q, push_data}),
    .pop_req   (iBlkRdy),
    .head_vld  (blk_vld),
    .head_data ({oBlkAddr, oBlkDt}),
    .count     (oFillCnt),
    .full      (fifo_full),
    .empty     (oEmpty)
  );

  assign oBlkVld = blk_vld;
  assign oFull   = fifo_full;
  assign oAsmErr = asm_err_q;
  assign oWrDrop = wr_drop_q;

endmodule
